regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Write-back side of the register file: collects results from two producers (A = single-cycle ALU,
//  B = load/multi-cycle unit), buffers them in a small in-order FIFO and drains at most one write per
//  cycle onto the regfile write port (rg_wrt_en/dest/data). Also exports a per-register pending
//  scoreboard and a forwarding lookup so decode can stall or bypass writes not yet in the regfile.
// PARAMETERS
//  DATA_WIDTH     32  bits per register / result
//  ADDRESS_WIDTH  5   register address width
//  NUM_REGS       32  number of architectural registers (pending vector width)
//  FIFO_DEPTH     4   write buffer entries; power of two, >= 2
// PORTS
//  clk          in   1              clock; all state updates on posedge
//  rst          in   1              asynchronous, active-low reset (0 = reset)
//  a_valid      in   1              producer A has a result
//  a_ready      out  1              A handshake completes when a_valid & a_ready
//  a_dest       in   ADDRESS_WIDTH  A destination register
//  a_data       in   DATA_WIDTH     A result
//  b_valid      in   1              producer B has a result
//  b_ready      out  1              B handshake completes when b_valid & b_ready
//  b_dest       in   ADDRESS_WIDTH  B destination register
//  b_data       in   DATA_WIDTH     B result
//  rg_wrt_en    out  1              regfile write strobe (registered)
//  rg_wrt_dest  out  ADDRESS_WIDTH  regfile write address (registered)
//  rg_wrt_data  out  DATA_WIDTH     regfile write data (registered)
//  pending      out  NUM_REGS       bit r = write to r buffered or on the write port
//  fwd_addr     in   ADDRESS_WIDTH  forwarding lookup address
//  fwd_hit      out  1              fwd_addr has a buffered/in-flight write
//  fwd_data     out  DATA_WIDTH     youngest buffered value for fwd_addr; 0 when !fwd_hit
// BEHAVIOUR
//  - Reset (rst=0, async): FIFO empty (count/ptrs 0), rg_wrt_en/dest/data = 0, pending = 0,
//    fwd_hit = 0, fwd_data = 0, a_ready = b_ready = 0 while rst=0. Reset mid-operation discards
//    all buffered writes; none reach the regfile.
//  - free = FIFO_DEPTH - count (registered count; same-cycle drain NOT credited).
//    a_ready = (free >= 1); b_ready = (free >= 2). No combinational path from valid to ready.
//  - Enqueue at posedge: A then B (A older when both accepted same cycle). count never > FIFO_DEPTH.
//  - dest == 0: handshake completes normally but nothing is enqueued (x0 writes dropped).
//  - Drain at posedge: if count > 0, pop head into rg_wrt_* and set rg_wrt_en=1; else rg_wrt_en=0
//    (dest/data hold). Enqueue and pop in the same cycle are allowed; count += enq - pop.
//  - Latency: result accepted at edge k -> rg_wrt_en high during cycle after edge k+1 (empty FIFO);
//    regfile captures it on the following negedge. Writes leave in exact acceptance order.
//  - pending[r] = OR(valid FIFO entries with dest r) | (rg_wrt_en & rg_wrt_dest == r); pending[0]=0.
//  - Forwarding (combinational): fwd_addr == 0 -> no hit. Else search youngest FIFO entry to oldest,
//    then the rg_wrt_* output register (write not yet captured before negedge); first match wins.
//  - Pointers wrap modulo FIFO_DEPTH; full and empty distinguished by count.
// TESTING
//  1. Empty FIFO, a_valid, a_dest=5, a_data=32'hDEADBEEF at edge k -> rg_wrt_en=1, dest 5, data
//     DEADBEEF exactly one cycle after edge k+1; pending[5]=1 from k through that write cycle.
//  2. Same cycle a(dest 3, 32'h11) and b(dest 3, 32'h22) -> writes 0x11 then 0x22 on consecutive
//     cycles; fwd_addr=3 returns 0x22 while both queued, 0x22 while on write port; fwd_hit then 0.
//  3. a_valid, a_dest=0, a_data=32'hFFFF -> a_ready handshake, no rg_wrt_en, pending unchanged;
//     fwd_addr=0 always gives fwd_hit=0.
//  4. Both producers valid every cycle, unique dests/data, 40 cycles -> b_ready drops when free<2,
//     count <= 4, every accepted write appears once, in acceptance order, no lost/duplicate data.
//  5. Fill 3 entries, drive rst=0 mid-cycle -> rg_wrt_en, pending, readies go 0 immediately; after
//     release no stale write issued, a_ready=b_ready=1.
//  6. Random valid/dest/data with scoreboard model, 10k cycles -> regfile contents, pending and
//     fwd_data match reference model every cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bundle: producer A/B handshakes, regfile write port,
// pending scoreboard and forwarding lookup.
interface regfile_wb_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_REGS      = 32
);
   logic                     a_valid;
   logic                     a_ready;
   logic [ADDRESS_WIDTH-1:0] a_dest;
   logic [DATA_WIDTH-1:0]    a_data;
   logic                     b_valid;
   logic                     b_ready;
   logic [ADDRESS_WIDTH-1:0] b_dest;
   logic [DATA_WIDTH-1:0]    b_data;
   logic                     rg_wrt_en;
   logic [ADDRESS_WIDTH-1:0] rg_wrt_dest;
   logic [DATA_WIDTH-1:0]    rg_wrt_data;
   logic [NUM_REGS-1:0]      pending;
   logic [ADDRESS_WIDTH-1:0] fwd_addr;
   logic                     fwd_hit;
   logic [DATA_WIDTH-1:0]    fwd_data;

   modport master (
      output a_valid, a_dest, a_data,
      output b_valid, b_dest, b_data,
      output fwd_addr,
      input  a_ready, b_ready,
      input  rg_wrt_en, rg_wrt_dest, rg_wrt_data,
      input  pending, fwd_hit, fwd_data
   );

   modport slave (
      input  a_valid, a_dest, a_data,
      input  b_valid, b_dest, b_data,
      input  fwd_addr,
      output a_ready, b_ready,
      output rg_wrt_en, rg_wrt_dest, rg_wrt_data,
      output pending, fwd_hit, fwd_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// In-order write-back buffer merging two producers onto one regfile
// write port, with pending scoreboard and youngest-first forwarding.
module regfile_wb_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int NUM_REGS      = 32,
   parameter int FIFO_DEPTH    = 4
) (
   input logic                  clk,
   input logic                  rst,
   regfile_wb_arbiter_if.slave  wb
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [ADDRESS_WIDTH-1:0] r_dest [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]    r_data [FIFO_DEPTH];
   logic [PW-1:0]            r_head;
   logic [PW-1:0]            r_tail;
   logic [CW-1:0]            r_count;
   logic                     r_wrt_en;
   logic [ADDRESS_WIDTH-1:0] r_wrt_dest;
   logic [DATA_WIDTH-1:0]    r_wrt_data;

   logic [CW-1:0]            w_free;
   logic                     w_a_enq;
   logic                     w_b_enq;
   logic                     w_pop;
   logic [PW-1:0]            w_b_slot;
   logic [CW-1:0]            w_enq_n;
   logic [PW-1:0]            w_idx;
   logic [NUM_REGS-1:0]      w_pending;
   logic                     w_hit;
   logic [DATA_WIDTH-1:0]    w_fwd;

   // Readiness uses the registered count only, so a drain this cycle
   // is not credited and B needs room for both producers at once.
   assign w_free     = CW'(FIFO_DEPTH) - r_count;
   assign wb.a_ready = rst & (w_free >= CW'(1));
   assign wb.b_ready = rst & (w_free >= CW'(2));

   assign w_a_enq  = wb.a_valid & wb.a_ready & (wb.a_dest != '0);
   assign w_b_enq  = wb.b_valid & wb.b_ready & (wb.b_dest != '0);
   assign w_pop    = (r_count != '0);
   assign w_b_slot = r_tail + PW'(w_a_enq);
   assign w_enq_n  = CW'(w_a_enq) + CW'(w_b_enq);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_dest[i] <= '0;
            r_data[i] <= '0;
         end
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_wrt_en   <= 1'b0;
         r_wrt_dest <= '0;
         r_wrt_data <= '0;
      end else begin
         if (w_a_enq) begin
            r_dest[r_tail] <= wb.a_dest;
            r_data[r_tail] <= wb.a_data;
         end
         if (w_b_enq) begin
            r_dest[w_b_slot] <= wb.b_dest;
            r_data[w_b_slot] <= wb.b_data;
         end
         r_tail   <= r_tail + PW'(w_enq_n);
         r_wrt_en <= w_pop;
         if (w_pop) begin
            r_head     <= r_head + PW'(1);
            r_wrt_dest <= r_dest[r_head];
            r_wrt_data <= r_data[r_head];
         end
         r_count <= r_count + w_enq_n - CW'(w_pop);
      end
   end

   // Walk oldest to youngest so the youngest match overrides; the
   // output register is seeded first as the oldest candidate.
   always_comb begin
      w_pending = '0;
      w_hit     = 1'b0;
      w_fwd     = '0;
      w_idx     = '0;
      if (r_wrt_en) begin
         w_pending[r_wrt_dest] = 1'b1;
         if (r_wrt_dest == wb.fwd_addr) begin
            w_hit = 1'b1;
            w_fwd = r_wrt_data;
         end
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
         w_idx = r_head + PW'(k);
         if (CW'(k) < r_count) begin
            w_pending[r_dest[w_idx]] = 1'b1;
            if (r_dest[w_idx] == wb.fwd_addr) begin
               w_hit = 1'b1;
               w_fwd = r_data[w_idx];
            end
         end
      end
      w_pending[0] = 1'b0;
      if (wb.fwd_addr == '0) begin
         w_hit = 1'b0;
         w_fwd = '0;
      end
   end

   assign wb.rg_wrt_en   = r_wrt_en;
   assign wb.rg_wrt_dest = r_wrt_dest;
   assign wb.rg_wrt_data = r_wrt_data;
   assign wb.pending     = w_pending;
   assign wb.fwd_hit     = w_hit;
   assign wb.fwd_data    = w_fwd;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// queue-based reference model of the write-back buffer.
module tb_regfile_wb_arbiter;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 32;
   localparam int D  = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR)
   ) wb ();

   regfile_wb_arbiter #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
      .NUM_REGS(NR), .FIFO_DEPTH(D)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wb(wb)
   );

   typedef struct packed {
      logic [AW-1:0] dest;
      logic [DW-1:0] data;
   } wr_t;

   wr_t           q[$];
   logic          m_en;
   logic [AW-1:0] m_dest;
   logic [DW-1:0] m_data;
   logic [DW-1:0] m_rf [NR];
   logic [DW-1:0] d_rf [NR];
   int            n_chk;
   int            n_fail;
   bit            saw_b_low;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      q.delete();
      m_en   = 1'b0;
      m_dest = '0;
      m_data = '0;
   endtask

   task automatic m_look(output logic [NR-1:0] p,
                         output logic hit,
                         output logic [DW-1:0] dat);
      p   = '0;
      hit = 1'b0;
      dat = '0;
      if (m_en) p[m_dest] = 1'b1;
      foreach (q[i]) p[q[i].dest] = 1'b1;
      p[0] = 1'b0;
      if (wb.fwd_addr != '0) begin
         for (int i = q.size() - 1; i >= 0 && !hit; i--) begin
            if (q[i].dest == wb.fwd_addr) begin
               hit = 1'b1;
               dat = q[i].data;
            end
         end
         if (!hit && m_en && m_dest == wb.fwd_addr) begin
            hit = 1'b1;
            dat = m_data;
         end
      end
   endtask

   task automatic check_all();
      logic [NR-1:0] p;
      logic          hit;
      logic [DW-1:0] dat;
      int            fr;
      m_look(p, hit, dat);
      fr = D - q.size();
      chk("a_ready", wb.a_ready, rst && fr >= 1);
      chk("b_ready", wb.b_ready, rst && fr >= 2);
      chk("rg_wrt_en", wb.rg_wrt_en, m_en);
      chk("rg_wrt_dest", wb.rg_wrt_dest, m_dest);
      chk("rg_wrt_data", wb.rg_wrt_data, m_data);
      chk("pending", wb.pending, p);
      chk("fwd_hit", wb.fwd_hit, hit);
      chk("fwd_data", wb.fwd_data, dat);
   endtask

   task automatic drive(bit av, logic [AW-1:0] ad, logic [DW-1:0] adt,
                        bit bv, logic [AW-1:0] bd, logic [DW-1:0] bdt,
                        logic [AW-1:0] fa);
      wb.a_valid  = av;
      wb.a_dest   = ad;
      wb.a_data   = adt;
      wb.b_valid  = bv;
      wb.b_dest   = bd;
      wb.b_data   = bdt;
      wb.fwd_addr = fa;
   endtask

   task automatic cycle();
      bit  aa;
      bit  ba;
      wr_t wa;
      wr_t wbb;
      wr_t h;
      aa  = rst && wb.a_valid && (D - q.size()) >= 1;
      ba  = rst && wb.b_valid && (D - q.size()) >= 2;
      wa  = '{dest: wb.a_dest, data: wb.a_data};
      wbb = '{dest: wb.b_dest, data: wb.b_data};
      @(posedge clk);
      if (rst) begin
         if (q.size() > 0) begin
            h      = q.pop_front();
            m_en   = 1'b1;
            m_dest = h.dest;
            m_data = h.data;
         end else begin
            m_en = 1'b0;
         end
         if (aa && wa.dest != '0) q.push_back(wa);
         if (ba && wbb.dest != '0) q.push_back(wbb);
      end
      @(negedge clk);
      check_all();
      if (!wb.b_ready) saw_b_low = 1'b1;
      if (m_en) m_rf[m_dest] = m_data;
      if (wb.rg_wrt_en === 1'b1) d_rf[wb.rg_wrt_dest] = wb.rg_wrt_data;
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      saw_b_low = 1'b0;
      for (int r = 0; r < NR; r++) begin
         m_rf[r] = '0;
         d_rf[r] = '0;
      end
      m_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b1;
      #1;
      chk("rel_a_ready", wb.a_ready, 1);
      chk("rel_b_ready", wb.b_ready, 1);

      // single ALU result latency and pending window
      drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5);
      cycle();
      chk("t1_pend5", wb.pending[5], 1);
      chk("t1_en_early", wb.rg_wrt_en, 0);
      chk("t1_fwd_q", wb.fwd_data, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0, 5);
      cycle();
      chk("t1_en", wb.rg_wrt_en, 1);
      chk("t1_dest", wb.rg_wrt_dest, 5);
      chk("t1_data", wb.rg_wrt_data, 32'hDEADBEEF);
      chk("t1_pend5_port", wb.pending[5], 1);
      cycle();
      chk("t1_en_off", wb.rg_wrt_en, 0);
      chk("t1_pend5_off", wb.pending[5], 0);

      // same-cycle A/B to one register
      drive(1, 3, 32'h11, 1, 3, 32'h22, 3);
      cycle();
      chk("t2_fwd_both", wb.fwd_data, 32'h22);
      drive(0, 0, 0, 0, 0, 0, 3);
      cycle();
      chk("t2_wr1", wb.rg_wrt_data, 32'h11);
      chk("t2_fwd_mid", wb.fwd_data, 32'h22);
      cycle();
      chk("t2_wr2", wb.rg_wrt_data, 32'h22);
      chk("t2_fwd_port", wb.fwd_data, 32'h22);
      cycle();
      chk("t2_hit_off", wb.fwd_hit, 0);

      // x0 write dropped
      drive(1, 0, 32'hFFFF, 0, 0, 0, 0);
      chk("t3_a_ready", wb.a_ready, 1);
      cycle();
      chk("t3_pend", wb.pending, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      cycle();
      chk("t3_en", wb.rg_wrt_en, 0);
      chk("t3_fwd0", wb.fwd_hit, 0);

      // saturating both producers
      saw_b_low = 1'b0;
      for (int i = 0; i < 40; i++) begin
         drive(1, AW'((2 * i) % 31 + 1), 32'hA000_0000 + i,
               1, AW'((2 * i + 1) % 31 + 1), 32'hB000_0000 + i,
               AW'(i % 31 + 1));
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (6) cycle();
      chk("t4_b_ready_drop", saw_b_low, 1);

      // reset with three buffered writes
      drive(1, 7, 32'h7777, 1, 8, 32'h8888, 7);
      cycle();
      drive(1, 9, 32'h9999, 1, 10, 32'hAAAA, 9);
      cycle();
      drive(0, 0, 0, 0, 0, 0, 9);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_en", wb.rg_wrt_en, 0);
      chk("t5_pend", wb.pending, 0);
      chk("t5_a_ready", wb.a_ready, 0);
      chk("t5_b_ready", wb.b_ready, 0);
      chk("t5_fwd", wb.fwd_hit, 0);
      m_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rel_a", wb.a_ready, 1);
      chk("t5_rel_b", wb.b_ready, 1);
      repeat (4) begin
         cycle();
         chk("t5_no_stale", wb.rg_wrt_en, 0);
      end

      // random traffic
      for (int i = 0; i < 10000; i++) begin
         drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               $urandom,
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               $urandom, AW'($urandom_range(0, 7)));
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (6) cycle();
      for (int r = 0; r < NR; r++) chk("regfile", d_rf[r], m_rf[r]);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
